// File: rtl/qspi_arbiter_if.sv
// Bus bundle between the debug/LISA requesters, the QSPI controller and qspi_arbiter.
// master = arbiter view, slave = requester/controller/config environment view.
interface qspi_arbiter_if #(
    parameter int CHIP_SELECTS = 2
);
    logic [2:0]                  req_valid;
    logic [71:0]                 req_addr;
    logic [47:0]                 req_wdata;
    logic [5:0]                  req_wstrb;
    logic [11:0]                 req_xfer_len;
    logic [3*CHIP_SELECTS-1:0]   req_ce_ctrl;
    logic [2:0]                  req_ready;
    logic [15:0]                 lisa1_base_addr;
    logic [15:0]                 lisa2_base_addr;
    logic [3:0]                  plus_guard_time;
    logic                        qspi_valid;
    logic [23:0]                 qspi_addr;
    logic [15:0]                 qspi_wdata;
    logic [1:0]                  qspi_wstrb;
    logic [3:0]                  qspi_xfer_len;
    logic [CHIP_SELECTS-1:0]     qspi_ce_ctrl;
    logic                        qspi_ready;
    logic [2:0]                  gnt;
    logic                        arb_timeout;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, req_xfer_len, req_ce_ctrl,
        input  lisa1_base_addr, lisa2_base_addr, plus_guard_time, qspi_ready,
        output req_ready, qspi_valid, qspi_addr, qspi_wdata, qspi_wstrb, qspi_xfer_len,
        output qspi_ce_ctrl, gnt, arb_timeout
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, req_xfer_len, req_ce_ctrl,
        output lisa1_base_addr, lisa2_base_addr, plus_guard_time, qspi_ready,
        input  req_ready, qspi_valid, qspi_addr, qspi_wdata, qspi_wstrb, qspi_xfer_len,
        input  qspi_ce_ctrl, gnt, arb_timeout
    );
endinterface

// File: rtl/qspi_arbiter.sv
// Shares one QSPI controller between debug, LISA1 and LISA2 with burst grants and a guard gap.
// Optional burst watchdog enabled by defining QSPI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate among valid requesters
// BUSY  | burst in progress for gnt_q
// GAP   | guard idle time after a burst
module qspi_arbiter #(
    parameter int CHIP_SELECTS   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    qspi_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        rr_q, rr_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [2:0]  win;
    logic [1:0]  widx, gidx;
    logic        gvalid;

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tcnt_q, tcnt_d;
    logic        to_q, to_set;
`endif

    // rr_q set means LISA2 wins the next LISA1/LISA2 tie
    always_comb begin
        win = 3'b000;
        if (bus.req_valid[0])                         win = 3'b001;
        else if (bus.req_valid[1] && bus.req_valid[2]) win = rr_q ? 3'b100 : 3'b010;
        else if (bus.req_valid[1])                    win = 3'b010;
        else if (bus.req_valid[2])                    win = 3'b100;
    end

    assign widx   = win[2]   ? 2'd2 : (win[1]   ? 2'd1 : 2'd0);
    assign gidx   = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);
    assign gvalid = bus.req_valid[gidx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            rr_q    <= 1'b0;
            wcnt_q  <= 4'd0;
            gcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
`ifdef QSPI_ARB_TIMEOUT_EN
        to_set  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win != 3'b000) begin
                    gnt_d   = win;
                    wcnt_d  = bus.req_xfer_len[4*widx +: 4];
                    state_d = BUSY;
                    if (!win[0]) rr_d = win[1];
                end
            end
            BUSY: begin
                if (!gvalid) begin
                    gnt_d   = 3'b000;
                    state_d = IDLE;
                end else if (bus.qspi_ready) begin
                    if (wcnt_q == 4'd0) begin
                        gnt_d = 3'b000;
                        if (bus.plus_guard_time != 4'd0) begin
                            state_d = GAP;
                            gcnt_d  = bus.plus_guard_time - 4'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
`ifdef QSPI_ARB_TIMEOUT_EN
                else if (tcnt_q == TCNT_LAST) begin
                    gnt_d   = 3'b000;
                    state_d = GAP;
                    gcnt_d  = (bus.plus_guard_time == 4'd0) ? 4'd0 : bus.plus_guard_time - 4'd1;
                    to_set  = 1'b1;
                end
`endif
            end
            GAP: begin
                if (gcnt_q == 4'd0) state_d = IDLE;
                else                gcnt_d  = gcnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.qspi_valid    = 1'b0;
        bus.qspi_addr     = 24'h000000;
        bus.qspi_wdata    = 16'h0000;
        bus.qspi_wstrb    = 2'b00;
        bus.qspi_xfer_len = 4'd0;
        bus.qspi_ce_ctrl  = '0;
        bus.req_ready     = 3'b000;
        if (state_q == BUSY) begin
            bus.qspi_valid    = gvalid;
            bus.qspi_wdata    = bus.req_wdata[16*gidx +: 16];
            bus.qspi_wstrb    = bus.req_wstrb[2*gidx +: 2];
            bus.qspi_xfer_len = bus.req_xfer_len[4*gidx +: 4];
            bus.qspi_ce_ctrl  = bus.req_ce_ctrl[CHIP_SELECTS*gidx +: CHIP_SELECTS];
            bus.req_ready     = gnt_q & {3{bus.qspi_ready}};
            // LISA relocation wraps at 16 MiB
            case (gidx)
                2'd1:    bus.qspi_addr = bus.req_addr[47:24] + {bus.lisa1_base_addr, 8'h00};
                2'd2:    bus.qspi_addr = bus.req_addr[71:48] + {bus.lisa2_base_addr, 8'h00};
                default: bus.qspi_addr = bus.req_addr[23:0];
            endcase
        end
    end

    assign bus.gnt = gnt_q;

`ifdef QSPI_ARB_TIMEOUT_EN
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == IDLE || bus.qspi_ready) tcnt_d = 8'd0;
        else if (state_q == BUSY)              tcnt_d = tcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 8'd0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= to_q | to_set;
        end
    end

    assign bus.arb_timeout = to_q;
`else
    assign bus.arb_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_qspi_arbiter.sv
// Self-checking bench for qspi_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (owner / words left / gap left / LISA preference).
`timescale 1ns/1ps
module tb_qspi_arbiter;
    localparam int CS = 2;
`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int TO_CYC = 8;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO_CYC = 255;
    localparam bit TO_EN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_arbiter_if #(.CHIP_SELECTS(CS)) bus();
    qspi_arbiter #(.CHIP_SELECTS(CS), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_owner, m_left, m_gap, m_stall;
    bit m_pref2, m_to;
    bit m_done [3];

    logic [2:0] exp_order [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
    logic [2:0] order [8];
    int ng, pulses, since, nv;
    bit act [3];

    task automatic check_eq(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act_v, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        logic [2:0]  e_gnt;
        logic [2:0]  e_rdy;
        logic        e_val;
        int unsigned e_addr;
        e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        e_val = (m_owner >= 0) && bus.req_valid[m_owner];
        e_rdy = (m_owner >= 0 && bus.qspi_ready) ? e_gnt : 3'b000;
        check_eq("gnt", bus.gnt, e_gnt);
        check_eq("qspi_valid", bus.qspi_valid, e_val);
        check_eq("req_ready", bus.req_ready, e_rdy);
        check_eq("arb_timeout", bus.arb_timeout, m_to);
        if (e_val) begin
            e_addr = bus.req_addr[24*m_owner +: 24];
            if (m_owner == 1) e_addr = e_addr + 256 * bus.lisa1_base_addr;
            if (m_owner == 2) e_addr = e_addr + 256 * bus.lisa2_base_addr;
            e_addr = e_addr % (1 << 24);
            check_eq("qspi_addr", bus.qspi_addr, e_addr);
            check_eq("qspi_wdata", bus.qspi_wdata, bus.req_wdata[16*m_owner +: 16]);
            check_eq("qspi_wstrb", bus.qspi_wstrb, bus.req_wstrb[2*m_owner +: 2]);
            check_eq("qspi_xfer_len", bus.qspi_xfer_len, bus.req_xfer_len[4*m_owner +: 4]);
            check_eq("qspi_ce_ctrl", bus.qspi_ce_ctrl, bus.req_ce_ctrl[CS*m_owner +: CS]);
        end
    endtask

    // Advances the reference model across one rising edge using the inputs now applied.
    task automatic model_step();
        int pick;
        if (rst) begin
            m_owner = -1; m_left = 0; m_gap = 0; m_stall = 0; m_pref2 = 1'b0; m_to = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            if (!bus.req_valid[m_owner]) begin
                m_owner = -1;
            end else if (bus.qspi_ready) begin
                m_stall = 0;
                m_left--;
                if (m_left == 0) begin
                    m_done[m_owner] = 1'b1;
                    m_owner = -1;
                    m_gap = int'(bus.plus_guard_time);
                end
            end else begin
                m_stall++;
                if (TO_EN && m_stall == TO_CYC) begin
                    m_done[m_owner] = 1'b1;
                    m_owner = -1;
                    m_to = 1'b1;
                    m_gap = (bus.plus_guard_time == 4'd0) ? 1 : int'(bus.plus_guard_time);
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            pick = -1;
            if (bus.req_valid[0])                          pick = 0;
            else if (bus.req_valid[1] && bus.req_valid[2]) pick = m_pref2 ? 2 : 1;
            else if (bus.req_valid[1])                     pick = 1;
            else if (bus.req_valid[2])                     pick = 2;
            if (pick >= 0) begin
                m_owner = pick;
                m_left  = int'(bus.req_xfer_len[4*pick +: 4]) + 1;
                m_stall = 0;
                if (pick != 0) m_pref2 = (pick == 1);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [23:0] a, input logic [3:0] len,
                           input logic [1:0] strb);
        bus.req_valid[i]            = v;
        bus.req_addr[24*i +: 24]    = a;
        bus.req_xfer_len[4*i +: 4]  = len;
        bus.req_wstrb[2*i +: 2]     = strb;
        bus.req_wdata[16*i +: 16]   = 16'($urandom);
        bus.req_ce_ctrl[CS*i +: CS] = CS'($urandom);
    endtask

    initial begin
        bus.req_valid       = '0;
        bus.req_addr        = '0;
        bus.req_wdata       = '0;
        bus.req_wstrb       = '0;
        bus.req_xfer_len    = '0;
        bus.req_ce_ctrl     = '0;
        bus.lisa1_base_addr = 16'h0000;
        bus.lisa2_base_addr = 16'h0000;
        bus.plus_guard_time = 4'd0;
        bus.qspi_ready      = 1'b0;

        // reset held for two cycles
        rst = 1'b1;
        cycle();
        chk_en = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("rst_gnt", bus.gnt, 3'b000);
        check_eq("rst_valid", bus.qspi_valid, 1'b0);
        check_eq("rst_timeout", bus.arb_timeout, 1'b0);

        set_req(1, 1'b1, 24'h000100, 4'd0, 2'b00);
        set_req(2, 1'b1, 24'h000200, 4'd0, 2'b00);
        cycle();
        check_eq("rr_first_lisa1", bus.gnt, 3'b010);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready = 1'b0;
        bus.req_valid  = 3'b000;
        cycle();

        // debug read with one guard cycle
        bus.plus_guard_time = 4'd1;
        set_req(0, 1'b1, 24'h001234, 4'd0, 2'b00);
        cycle();
        check_eq("dbg_valid", bus.qspi_valid, 1'b1);
        check_eq("dbg_addr", bus.qspi_addr, 24'h001234);
        bus.qspi_ready = 1'b1;
        #1;
        check_eq("dbg_req_ready", bus.req_ready, 3'b001);
        cycle();
        bus.qspi_ready   = 1'b0;
        bus.req_valid[0] = 1'b0;
        #1;
        check_eq("gap_gnt", bus.gnt, 3'b000);
        check_eq("gap_valid", bus.qspi_valid, 1'b0);
        cycle();
        bus.req_valid[0] = 1'b1;
        cycle();
        check_eq("gap_len1_regrant", bus.gnt, 3'b001);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready   = 1'b0;
        bus.req_valid[0] = 1'b0;
        cycle();
        bus.plus_guard_time = 4'd0;

        // LISA2 relocation, including wrap
        bus.lisa2_base_addr = 16'hFFFF;
        set_req(2, 1'b1, 24'h0000F0, 4'd0, 2'b00);
        cycle();
        check_eq("reloc_wrap", bus.qspi_addr, 24'hFFFFF0);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready = 1'b0;
        bus.lisa2_base_addr = 16'h0012;
        cycle();
        check_eq("reloc_0012", bus.qspi_addr, 24'h0012F0);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready   = 1'b0;
        bus.req_valid[2] = 1'b0;
        cycle();

        // priority and fairness: all valid, single-word bursts, no guard
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 24'(k * 24'h010000 + k), 4'd0, 2'b00);
        bus.qspi_ready = 1'b1;
        ng = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (bus.gnt != 3'b000 && ng < 8) begin
                order[ng] = bus.gnt;
                ng++;
            end
            if (i == 8) bus.req_valid[0] = 1'b0;
        end
        check_eq("order_count", ng, 8);
        for (int k = 0; k < 8; k++) check_eq($sformatf("order%0d", k), order[k], exp_order[k]);
        bus.req_valid  = 3'b000;
        bus.qspi_ready = 1'b0;
        cycle();

        // four-word LISA1 burst, ready every other cycle, LISA2 waits for burst + guard
        bus.plus_guard_time = 4'd2;
        set_req(1, 1'b1, 24'h004000, 4'd3, 2'b11);
        cycle();
        check_eq("burst_grant", bus.gnt, 3'b010);
        pulses = 0;
        since  = -1;
        for (int i = 0; i < 40 && bus.gnt != 3'b100; i++) begin
            bus.qspi_ready = (pulses < 4) ? i[0] : 1'b0;
            if (i == 2) set_req(2, 1'b1, 24'h000800, 4'd0, 2'b10);
            #1;
            if (pulses < 4) check_eq("burst_gnt_hold", bus.gnt, 3'b010);
            if (bus.req_ready[1]) pulses++;
            if (pulses == 4 && since < 0) since = 0;
            cycle();
            if (since >= 0) since++;
            if (pulses == 4) bus.req_valid[1] = 1'b0;
        end
        check_eq("burst_pulses", pulses, 4);
        check_eq("lisa2_after_guard", since, 4);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready      = 1'b0;
        bus.req_valid       = 3'b000;
        bus.plus_guard_time = 4'd0;
        cycle();
        cycle();

        // reset in the middle of a burst
        set_req(0, 1'b1, 24'h000ABC, 4'd5, 2'b01);
        cycle();
        bus.qspi_ready = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req_valid = 3'b000;
        #1;
        check_eq("rst_mid_gnt", bus.gnt, 3'b000);
        check_eq("rst_mid_valid", bus.qspi_valid, 1'b0);
        check_eq("rst_mid_ready", bus.req_ready, 3'b000);
        bus.qspi_ready = 1'b0;
        cycle();

`ifdef QSPI_ARB_TIMEOUT_EN
        set_req(1, 1'b1, 24'h000300, 4'd0, 2'b00);
        cycle();
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.qspi_valid) nv++;
            if (bus.arb_timeout) bus.req_valid[1] = 1'b0;
            cycle();
        end
        check_eq("to_valid_cycles", nv, 8);
        check_eq("to_flag", bus.arb_timeout, 1'b1);
        cycle();
        cycle();
        check_eq("to_sticky", bus.arb_timeout, 1'b1);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("to_cleared", bus.arb_timeout, 1'b0);
`else
        set_req(1, 1'b1, 24'h000300, 4'd0, 2'b00);
        for (int i = 0; i < 20; i++) cycle();
        check_eq("no_to_valid", bus.qspi_valid, 1'b1);
        check_eq("no_to_flag", bus.arb_timeout, 1'b0);
        bus.qspi_ready = 1'b1;
        cycle();
        bus.qspi_ready = 1'b0;
        bus.req_valid  = 3'b000;
        cycle();
`endif

        // random traffic
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 1'b0;
            act[k]    = 1'b0;
        end
        bus.lisa1_base_addr = 16'($urandom);
        bus.lisa2_base_addr = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (m_done[k]) begin
                    act[k]    = 1'b0;
                    m_done[k] = 1'b0;
                end
                if (act[k] && $urandom_range(0, 63) == 0) begin
                    act[k] = 1'b0;
                end else if (!act[k] && $urandom_range(0, (k == 0) ? 15 : 3) == 0) begin
                    act[k] = 1'b1;
                    set_req(k, 1'b1, 24'($urandom), 4'($urandom), 2'($urandom));
                end
                bus.req_valid[k] = act[k];
                if (act[k]) bus.req_wdata[16*k +: 16] = 16'($urandom);
            end
            bus.qspi_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.plus_guard_time = 4'($urandom_range(0, 3));
            if (c == 2000) begin
                bus.lisa1_base_addr = 16'($urandom);
                bus.lisa2_base_addr = 16'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qspi_arbiter.md
Name: qspi_arbiter

Overview:
- Shares the single QSPI memory controller between three requesters: debug port, LISA1 and LISA2.
- Grants one requester at a time for a full burst and routes that requester's chip select.
- Applies the LISA base-address relocation to LISA requests.
- Inserts a programmable guard gap between transactions.
- Sits between the debug register block and cache front-ends on one side and the QSPI controller on the other.

Parameters:
- CHIP_SELECTS, 2, number of QSPI chip-enable lines.
- TIMEOUT_CYCLES, 255, cycles without qspi_ready before a burst is aborted (used only when QSPI_ARB_TIMEOUT_EN is defined).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  3  request valid; bit0 debug, bit1 LISA1, bit2 LISA2
- req_addr  in  72  24-bit byte address per requester; requester i at [24i+23:24i]
- req_wdata  in  48  16-bit write data per requester
- req_wstrb  in  6  2-bit byte strobes per requester; 0 = read
- req_xfer_len  in  12  4-bit word count minus one per requester
- req_ce_ctrl  in  3*CHIP_SELECTS  chip-select vector per requester
- req_ready  out  3  per-word ready, routed to the granted requester only
- lisa1_base_addr  in  16  LISA1 relocation base, 256-byte units
- lisa2_base_addr  in  16  LISA2 relocation base, 256-byte units
- plus_guard_time  in  4  idle cycles inserted after each burst
- qspi_valid  out  1  request to QSPI controller
- qspi_addr  out  24  address to controller
- qspi_wdata  out  16  write data
- qspi_wstrb  out  2  write strobes
- qspi_xfer_len  out  4  words minus one
- qspi_ce_ctrl  out  CHIP_SELECTS  chip selects for this burst
- qspi_ready  in  1  controller word-complete strobe
- gnt  out  3  one-hot current grant
- arb_timeout  out  1  sticky timeout flag (tied 0 without the macro)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - gnt=0, qspi_valid=0, req_ready=0, arb_timeout=0.
  - Word counter 0, guard counter 0.
  - Round-robin pointer prefers LISA1.
  - Reset mid-burst abandons the burst immediately with no completion.
- States: IDLE, BUSY, GAP.
- IDLE:
  - Samples req_valid each cycle.
  - Debug (bit0) has absolute priority.
  - Otherwise LISA1 and LISA2 alternate round-robin; the pointer flips to the other LISA after each LISA grant.
  - On a winner, the registered gnt is set, the word counter is loaded from that requester's xfer_len, and the state moves to BUSY.
  - Latency is 1 cycle: request seen in cycle N gives qspi_valid high in cycle N+1.
- BUSY:
  - qspi_valid = req_valid[granted] (combinational gate).
  - Data, strobe, length and CE fields are muxed combinationally from the granted requester.
  - qspi_addr = req_addr for debug. For LISAn it is req_addr + {lisaN_base_addr, 8'h00}, modulo 2^24 (wraps, no carry-out).
  - req_ready[g] = qspi_ready. All other req_ready bits are 0.
  - On qspi_ready with counter != 0: decrement the counter.
  - On qspi_ready with counter == 0 (final word): burst done. Go to GAP if plus_guard_time != 0, else to IDLE. gnt clears next cycle.
  - Granted requester drops valid before the final word: abort, go to IDLE next cycle, no guard gap.
- GAP:
  - qspi_valid=0 and gnt=0.
  - Counts plus_guard_time cycles, then goes to IDLE.
  - plus_guard_time is sampled at GAP entry.
- Requests arriving during BUSY or GAP wait; they are never dropped while held valid.
- qspi_ready outside BUSY is ignored.
- req_xfer_len=0 means one word. 15 means 16 words.
- A new request that is valid in the same cycle as the final ready is arbitrated only after IDLE is reached.

Optional Feature:
- Macro: QSPI_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on grant and on each qspi_ready, and increments in BUSY.
  - When it reaches TIMEOUT_CYCLES, the arbiter deasserts qspi_valid, sets the sticky arb_timeout (cleared only by rst) and enters GAP.
  - req_ready is not pulsed for the aborted words.
- When undefined: no counter, a burst may wait forever, arb_timeout is tied 0.

Test Plan:
- Reset: hold rst 2 cycles -> gnt=0, qspi_valid=0, arb_timeout=0. LISA1 and LISA2 then requesting together -> LISA1 granted first.
- Debug read: debug addr 24'h001234, xfer_len 0, guard 1 -> qspi_valid the next cycle with qspi_addr 24'h001234. One qspi_ready -> req_ready[0] pulse, then 1 GAP cycle, then IDLE.
- Relocation: LISA2 addr 24'h0000F0, lisa2_base_addr 16'hFFFF -> qspi_addr 24'hFFFFF0. Base 16'h0012 -> 24'h0012F0.
- Priority/fairness: all three valid continuously, single-word bursts, guard 0 -> grant order debug, debug… until debug drops. Then LISA1, LISA2, LISA1, LISA2.
- Burst: LISA1 xfer_len 3, ready every other cycle -> exactly 4 req_ready[1] pulses, gnt held throughout. LISA2 requesting mid-burst is granted only after the 4th ready plus the guard.
- Timeout (macro on, TIMEOUT_CYCLES=8): grant with no qspi_ready -> qspi_valid drops after 8 BUSY cycles, arb_timeout=1 and stays 1 until rst.
